// File: rtl/group_generator_pkg.sv
// Shared types and constants for the permutation group generator.
package groupPkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  localparam logic [4:0] GROUP_COUNT = 5'd24;
  localparam int         DIGIT_W     = 4;

  // Lehmer-code place weights for a 4-element permutation: 3!, 2!, 1!.
  localparam logic [4:0] FACT_W0 = 5'd6;
  localparam logic [4:0] FACT_W1 = 5'd2;
  localparam logic [4:0] FACT_W2 = 5'd1;

  // Digit (1..4) of the lowest set bit in an availability mask; 0 if empty.
  function automatic logic [DIGIT_W-1:0] first_set_digit(input logic [3:0] mask);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) d = DIGIT_W'(i + 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/group_digit_picker.sv
// Returns the k-th available digit of a mask (bit i = digit i+1) and the
// mask with that digit removed.
module group_digit_picker
  import groupPkg::*;
(
  input  logic [3:0]         i_mask,
  input  logic [1:0]         i_k,
  output logic [DIGIT_W-1:0] o_digit,
  output logic [3:0]         o_mask
);

  logic [2:0] w_cnt;
  logic       w_found;

  // Walk the mask from digit 1 upward, counting available digits until the k-th.
  always_comb begin
    o_digit = '0;
    o_mask  = i_mask;
    w_cnt   = 3'd0;
    w_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i_mask[i] && !w_found) begin
        if (w_cnt == {1'b0, i_k}) begin
          o_digit   = DIGIT_W'(i + 1);
          o_mask[i] = 1'b0;
          w_found   = 1'b1;
        end
        w_cnt = w_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/group_generator.sv
// Lexicographic permutation generator for the digits 1..4.
// Outputs are registered views of the FSM, so they trail the state by one
// cycle: busy spans three cycles and groupValid rises on the 4th edge.
//
//   state     | meaning
//   ST_IDLE   | waiting for start, outputs cleared
//   ST_DECODE | three-step Lehmer decode of r_index into r_dig
//   ST_READY  | r_dig holds a complete permutation, accepts start/next
module group_generator
  import groupPkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  seed,
  input  logic        next,
  output logic [15:0] groupDigits,
  output logic        groupValid,
  output logic        busy,
  output logic        wrapped
);

  state_t r_state, w_state_next;

  logic [4:0]         r_index, r_rem;
  logic [3:0]         r_mask;
  logic [1:0]         r_step;
  logic [15:0]        r_dig;
  logic               r_wrap_pend;
  logic [15:0]        r_out_digits;
  logic               r_valid, r_busy, r_wrapped;

  logic               w_load_start, w_load_next;
  logic [4:0]         w_seed_idx, w_index_inc;
  logic [4:0]         w_fact, w_rem_next;
  logic [1:0]         w_k;
  logic [DIGIT_W-1:0] w_dig;
  logic [3:0]         w_mask_upd;

  group_digit_picker u_picker (
    .i_mask  (r_mask),
    .i_k     (w_k),
    .o_digit (w_dig),
    .o_mask  (w_mask_upd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode; start wins over next, both ignored while decoding.
  always_comb begin
    w_state_next = r_state;
    w_load_start = 1'b0;
    w_load_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load_start = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (r_step == 2'd2) w_state_next = ST_READY;
      end
      ST_READY: begin
        if (start) begin
          w_load_start = 1'b1;
          w_state_next = ST_DECODE;
        end else if (next) begin
          w_load_next  = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Index arithmetic and per-step Lehmer weight selection.
  always_comb begin
    w_seed_idx  = (seed >= GROUP_COUNT) ? seed - GROUP_COUNT : seed;
    w_index_inc = (r_index == GROUP_COUNT - 5'd1) ? 5'd0 : r_index + 5'd1;
    case (r_step)
      2'd0:    w_fact = FACT_W0;
      2'd1:    w_fact = FACT_W1;
      default: w_fact = FACT_W2;
    endcase
    w_k        = 2'(r_rem / w_fact);
    w_rem_next = r_rem % w_fact;
  end

  // Decode datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index      <= '0;
      r_rem        <= '0;
      r_mask       <= '0;
      r_step       <= '0;
      r_dig        <= '0;
      r_wrap_pend  <= 1'b0;
      r_out_digits <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_wrapped    <= 1'b0;
    end else begin
      if (w_load_start) begin
        r_index     <= w_seed_idx;
        r_rem       <= w_seed_idx;
        r_mask      <= 4'hF;
        r_step      <= 2'd0;
        r_dig       <= '0;
        r_wrap_pend <= 1'b0;
      end else if (w_load_next) begin
        r_index     <= w_index_inc;
        r_rem       <= w_index_inc;
        r_mask      <= 4'hF;
        r_step      <= 2'd0;
        r_dig       <= '0;
        r_wrap_pend <= (w_index_inc == 5'd0);
      end else if (r_state == ST_DECODE) begin
        r_step <= r_step + 2'd1;
        r_mask <= w_mask_upd;
        r_rem  <= w_rem_next;
        case (r_step)
          2'd0: r_dig[15:12] <= w_dig;
          2'd1: r_dig[11:8]  <= w_dig;
          default: begin
            r_dig[7:4] <= w_dig;
            r_dig[3:0] <= first_set_digit(w_mask_upd);
          end
        endcase
      end
      r_busy       <= (r_state == ST_DECODE);
      r_valid      <= (r_state == ST_READY);
      r_out_digits <= (r_state == ST_READY) ? r_dig : 16'h0000;
      r_wrapped    <= (r_state == ST_READY) && !r_valid && r_wrap_pend;
    end
  end

  assign groupDigits = r_out_digits;
  assign groupValid  = r_valid;
  assign busy        = r_busy;
  assign wrapped     = r_wrapped;

endmodule
